alu_exec_unit: RTL

//   Integer execute stage directly downstream of the reservation station.
//   - Accepts at most one issued op per cycle (rs_ready/rs_op/rs_val1/rs_val2/rs_id) and computes the result.
//   - Broadcasts result + ROB id (alu_ready/alu_res/alu_id) to the RS wakeup logic, the ROB and the LSB.
//   - Has no backpressure: the RS issues freely, so the unit accepts an op every cycle.

---
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Issue/broadcast bundle between the reservation station and the integer execute unit.
// master = issuing side (drives rs_*), slave = execute unit (drives alu_*).
interface alu_exec_unit_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 4,
  parameter int OP_W = 4
);
  logic            rs_ready;
  logic [OP_W-1:0] rs_op;
  logic [XLEN-1:0] rs_val1;
  logic [XLEN-1:0] rs_val2;
  logic [ID_W-1:0] rs_id;

  logic            alu_ready;
  logic [XLEN-1:0] alu_res;
  logic [ID_W-1:0] alu_id;

  modport master (
    output rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    input  alu_ready, alu_res, alu_id
  );

  modport slave (
    input  rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    output alu_ready, alu_res, alu_id
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execute stage: one op accepted per cycle, result + ROB id broadcast one cycle later.
// Optional macro ALU_OPREG_EN adds an operand register stage (latency 2, still 1 op/cycle).
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int ID_W = 4,
  parameter int OP_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  input  logic flush,
  alu_exec_unit_if.slave bus
);

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SHL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SHR  = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SHRA = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_EQ   = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_NEQ  = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_LT   = OP_W'(10);
  localparam logic [OP_W-1:0] ALU_LTU  = OP_W'(11);
  localparam logic [OP_W-1:0] ALU_GE   = OP_W'(12);
  localparam logic [OP_W-1:0] ALU_GEU  = OP_W'(13);

  // Unknown encodings yield 0 but still complete, so the ROB entry retires.
  function automatic logic [XLEN-1:0] aluCompute(
    input logic [OP_W-1:0] op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic        [4:0]      sh;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    aluCompute = '0;
    case (op)
      ALU_ADD:  aluCompute = a + b;
      ALU_SUB:  aluCompute = a - b;
      ALU_AND:  aluCompute = a & b;
      ALU_OR:   aluCompute = a | b;
      ALU_XOR:  aluCompute = a ^ b;
      ALU_SHL:  aluCompute = a << sh;
      ALU_SHR:  aluCompute = a >> sh;
      ALU_SHRA: aluCompute = sa >>> sh;
      ALU_EQ:   aluCompute = XLEN'(a == b);
      ALU_NEQ:  aluCompute = XLEN'(a != b);
      ALU_LT:   aluCompute = XLEN'(sa < sb);
      ALU_LTU:  aluCompute = XLEN'(a < b);
      ALU_GE:   aluCompute = XLEN'(sa >= sb);
      ALU_GEU:  aluCompute = XLEN'(a >= b);
      default:  aluCompute = '0;
    endcase
  endfunction

  logic            aluReady_q;
  logic [XLEN-1:0] aluRes_q;
  logic [ID_W-1:0] aluId_q;
  logic [XLEN-1:0] res_d;

`ifdef ALU_OPREG_EN
  logic            s1Valid_q;
  logic [OP_W-1:0] s1Op_q;
  logic [XLEN-1:0] s1Val1_q;
  logic [XLEN-1:0] s1Val2_q;
  logic [ID_W-1:0] s1Id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= '0;
      s1Val1_q  <= '0;
      s1Val2_q  <= '0;
      s1Id_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        s1Valid_q <= 1'b0;
      end else begin
        s1Valid_q <= bus.rs_ready;
        if (bus.rs_ready) begin
          s1Op_q   <= bus.rs_op;
          s1Val1_q <= bus.rs_val1;
          s1Val2_q <= bus.rs_val2;
          s1Id_q   <= bus.rs_id;
        end
      end
    end
  end

  assign res_d = aluCompute(s1Op_q, s1Val1_q, s1Val2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluReady_q <= 1'b0;
      aluRes_q   <= '0;
      aluId_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        aluReady_q <= 1'b0;
      end else begin
        aluReady_q <= s1Valid_q;
        if (s1Valid_q) begin
          aluRes_q <= res_d;
          aluId_q  <= s1Id_q;
        end
      end
    end
  end
`else
  assign res_d = aluCompute(bus.rs_op, bus.rs_val1, bus.rs_val2);

  // Result/id only update on an accepted op; they are stale but harmless while alu_ready=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluReady_q <= 1'b0;
      aluRes_q   <= '0;
      aluId_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        aluReady_q <= 1'b0;
      end else begin
        aluReady_q <= bus.rs_ready;
        if (bus.rs_ready) begin
          aluRes_q <= res_d;
          aluId_q  <= bus.rs_id;
        end
      end
    end
  end
`endif

  assign bus.alu_ready = aluReady_q;
  assign bus.alu_res   = aluRes_q;
  assign bus.alu_id    = aluId_q;

endmodule
